data_mem_ctrl: RTL and testbench

Parametrised RV32 data-memory controller that replaces the flat word-only data memory on the core's load/store path. It accepts one request at a time over a req/gnt handshake and decodes RV32 load/store size from funct3 (byte, half, word, signed or unsigned). It performs byte-lane writes and sign/zero-extended reads, and returns every access through a one-cycle rvalid/err response. A small FSM sequences storage accesses, including an optional two-beat split for word-crossing misaligned accesses.

---
 rtl/dmem_pkg.sv | 58 +++++
 rtl/dmem_bank.sv | 34 +++
 rtl/data_mem_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory controller.
//   size_e  : RV32 funct3 load/store size codes.
//   state_e : controller FSM states.
//   byte_en / lane_shift : byte enables and store lanes for one beat of an
//     access. The lower beat covers the first word and the upper beat covers
//     the following word. The upper beat is used only for word-crossing
//     accesses, and only when DMEM_MISALIGN_EN is defined.
//   ld_extend : sign or zero extension of right-aligned load data.
package dmem_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } size_e;

  typedef enum logic [1:0] {ST_IDLE, ST_ACC0, ST_ACC1, ST_RESP} state_e;

  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3)
      SZ_B, SZ_BU: return 4'b0001;
      SZ_H, SZ_HU: return 4'b0011;
      SZ_W:        return 4'b1111;
      default:     return 4'b0000;
    endcase
  endfunction

  // hi=0: lanes that land in the first word. hi=1: lanes that spill into the next word.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off,
                                         input logic hi);
    logic [3:0] m;
    m = size_mask(f3);
    if (!hi) return m << off;
    if (off == 2'd0) return 4'b0000;
    return m >> (3'd4 - {1'b0, off});
  endfunction

  function automatic logic [31:0] lane_shift(input logic [31:0] d, input logic [1:0] off,
                                             input logic hi);
    if (!hi) return d << {off, 3'b000};
    if (off == 2'd0) return 32'h0;
    return d >> (6'd32 - {1'b0, off, 3'b000});
  endfunction

  function automatic logic [31:0] ld_extend(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      SZ_B:    return {{24{w[7]}}, w[7:0]};
      SZ_BU:   return {24'h0, w[7:0]};
      SZ_H:    return {{16{w[15]}}, w[15:0]};
      SZ_HU:   return {16'h0, w[15:0]};
      SZ_W:    return w;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: single-port DEPTH_WORDS x 32 storage.
// It has per-byte write enables and a registered read with 1-cycle latency.
// Contents are not reset.
//   clk   : clock
//   ce    : port enable (read, or write when we=1)
//   we    : write
//   be    : byte enables, qualified by we
//   addr  : word index
//   wdata : lane-aligned write data
//   rdata : word read on the previous enabled edge
module dmem_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          ce,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (ce) begin
      for (int b = 0; b < 4; b++)
        if (we && be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: RV32 data-memory controller.
// It uses a req/gnt request handshake and returns a one-cycle rvalid/err response.
// Sizes are decoded from funct3. Stores are byte-lane writes. Loads are sign- or
// zero-extended. Faults are decided at accept and skip the storage access.
// Optional macro DMEM_MISALIGN_EN:
//   - A half at offset 1 runs in one beat.
//   - A word-crossing access runs as a two-beat split (ACC0 then ACC1).
//   - Without the macro, any misaligned half or word is a fault.
// Ports:
//   clk, rst                       : clock, async active-high reset
//   req, we, addr, funct3, wdata   : request; fields are captured at accept
//   gnt                            : ready, high only in IDLE and not in reset
//   rvalid, rdata, err             : response, registered out of RESP
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [31:0]       wdata,
  output logic              gnt,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH_WORDS);

  state_e state, state_nx;

  logic          we_q, fault_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
`ifdef DMEM_MISALIGN_EN
  logic          split_q;
  logic [31:0]   lo_q;
  logic          split_acc;
`else
  logic          misal;
`endif

  logic              bank_ce, bank_we;
  logic [3:0]        bank_be;
  logic [AW-1:0]     bank_addr;
  logic [31:0]       bank_wdata, bank_rdata;
  logic [ADDR_W-1:0] idx_full;
  logic              bad_f3, oor, acc_fault;
  logic [31:0]       ld_word;

  // Request decode; only meaningful on the accept edge
  always_comb begin
    idx_full = {2'b00, addr[ADDR_W-1:2]};
    bad_f3   = funct3 inside {3'b011, 3'b110, 3'b111};
    oor      = idx_full >= DEPTH_L;
`ifdef DMEM_MISALIGN_EN
    split_acc = !bad_f3 && ((((funct3 == SZ_H) || (funct3 == SZ_HU)) && addr[1:0] == 2'd3) ||
                            ((funct3 == SZ_W) && addr[1:0] != 2'd0));
    acc_fault = bad_f3 || oor || (split_acc && (idx_full + 1'b1) >= DEPTH_L);
`else
    misal     = (((funct3 == SZ_H) || (funct3 == SZ_HU)) && addr[0]) ||
                ((funct3 == SZ_W) && addr[1:0] != 2'd0);
    acc_fault = bad_f3 || oor || misal;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      f3_q    <= 3'b0;
      off_q   <= 2'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
`ifdef DMEM_MISALIGN_EN
      split_q <= 1'b0;
`endif
    end else if (req && gnt) begin
      we_q    <= we;
      fault_q <= acc_fault;
      f3_q    <= funct3;
      off_q   <= addr[1:0];
      idx_q   <= addr[AW+1:2];
      wdata_q <= wdata;
`ifdef DMEM_MISALIGN_EN
      split_q <= split_acc;
`endif
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (req) state_nx = acc_fault ? ST_RESP : ST_ACC0;
`ifdef DMEM_MISALIGN_EN
      ST_ACC0: state_nx = split_q ? ST_ACC1 : ST_RESP;
      ST_ACC1: state_nx = ST_RESP;
`else
      ST_ACC0: state_nx = ST_RESP;
`endif
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM: outputs and bank control
  always_comb begin
    gnt        = (state == ST_IDLE) && !rst;
    bank_ce    = 1'b0;
    bank_we    = 1'b0;
    bank_be    = 4'b0;
    bank_addr  = idx_q;
    bank_wdata = lane_shift(wdata_q, off_q, 1'b0);
    case (state)
      ST_ACC0: begin
        bank_ce = 1'b1;
        bank_we = we_q;
        bank_be = byte_en(f3_q, off_q, 1'b0);
      end
`ifdef DMEM_MISALIGN_EN
      ST_ACC1: begin
        bank_ce    = 1'b1;
        bank_we    = we_q;
        bank_be    = byte_en(f3_q, off_q, 1'b1);
        bank_addr  = idx_q + 1'b1;
        bank_wdata = lane_shift(wdata_q, off_q, 1'b1);
      end
`endif
      default: ;
    endcase
  end

  dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_bank (
    .clk   (clk),
    .ce    (bank_ce),
    .we    (bank_we),
    .be    (bank_be),
    .addr  (bank_addr),
    .wdata (bank_wdata),
    .rdata (bank_rdata)
  );

  // Right-align the loaded bytes. A split access merges the held lower word
  // with the upper word that is now on the bank output.
  always_comb begin
`ifdef DMEM_MISALIGN_EN
    if (split_q)
      ld_word = (lo_q >> {off_q, 3'b000}) |
                (bank_rdata << (6'd32 - {1'b0, off_q, 3'b000}));
    else
      ld_word = bank_rdata >> {off_q, 3'b000};
`else
    ld_word = bank_rdata >> {off_q, 3'b000};
`endif
  end

`ifdef DMEM_MISALIGN_EN
  // Lower-word read data is still on the bank output during ACC1
  always_ff @(posedge clk) begin
    if (state == ST_ACC1) lo_q <= bank_rdata;
  end
`endif

  // The response is registered out of RESP, so rvalid lands on the edge leaving RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= 32'h0;
    end else begin
      rvalid <= (state == ST_RESP);
      err    <= (state == ST_RESP) && fault_q;
      rdata  <= ((state == ST_RESP) && !fault_q && !we_q) ? ld_extend(f3_q, ld_word) : 32'h0;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: self-checking bench for data_mem_ctrl with DEPTH_WORDS=16.
// The reference model is a byte array that applies RV32 load/store rules directly.
// Expectations follow DMEM_MISALIGN_EN when it is defined for the build.
module tb_data_mem_ctrl;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [31:0] addr, wdata, rdata;
  logic [2:0]  funct3;
  logic        gnt, rvalid, err;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] mem [DEPTH*4];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [2:0]  f;
    logic [31:0] d;
    logic        e;
    logic [31:0] r;
    int          lat;
  } vec_t;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .funct3(funct3),
    .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err)
  );

  // Byte-level reference. lat is the number of edges from accept to rvalid.
  function automatic void model(input logic w, input logic [31:0] a32, input logic [2:0] f,
                                input logic [31:0] d, output logic e, output logic [31:0] r,
                                output int lat);
    int n, a, off;
    bit sgn;
    n = 0; sgn = 0; e = 0; r = 0; lat = 1;
    case (f)
      3'd0: begin n = 1; sgn = 1; end
      3'd4: n = 1;
      3'd1: begin n = 2; sgn = 1; end
      3'd5: n = 2;
      3'd2: n = 4;
      default: n = 0;
    endcase
    a = int'(a32);
    off = a % 4;
    if (n == 0 || a / 4 >= DEPTH) e = 1;
    else if (a % n != 0) begin
`ifdef DMEM_MISALIGN_EN
      if (off + n > 4 && a / 4 + 1 >= DEPTH) e = 1;
`else
      e = 1;
`endif
    end
    if (e) return;
    lat = (off + n > 4) ? 3 : 2;
    if (w) begin
      for (int i = 0; i < n; i++) mem[a+i] = d[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) r[8*i +: 8] = mem[a+i];
      if (sgn && r[8*n-1]) r = r | (32'hFFFF_FFFF << (8*n));
    end
  endfunction

  // Drive one request and wait for its response.
  // stuck reports that rvalid is still high one edge later.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [2:0] f,
                        input logic [31:0] d, output logic e, output logic [31:0] r,
                        output int lat, output logic stuck);
    int k;
    e = 0; r = 0; lat = 0; stuck = 0;
    @(negedge clk);
    req = 1; we = w; addr = a; funct3 = f; wdata = d;
    k = 0;
    while (!gnt && k < 10) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    req = 0; we = 1'($urandom); addr = $urandom; funct3 = 3'($urandom); wdata = $urandom;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (rvalid) begin lat = c; e = err; r = rdata; break; end
    end
    @(posedge clk); #1;
    stuck = rvalid;
  endtask

  task automatic test_reset();
    rst = 1; req = 0; we = 0; addr = 0; funct3 = 0; wdata = 0;
    #12;
    n_vec++; if (gnt !== 1'b0)   begin n_bad++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    n_vec++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    n_vec++; if (err !== 1'b0)    begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_vec++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    @(negedge clk); rst = 0; #1;
    n_vec++; if (gnt !== 1'b1)   begin n_bad++; $display("FAIL release_gnt: got %b want 1", gnt); end
  endtask

  task automatic run_table(input string tag, input vec_t tbl[], input int cnt);
    logic e, stuck;
    logic [31:0] r;
    int lat;
    for (int i = 0; i < cnt; i++) begin
      do_req(tbl[i].w, tbl[i].a, tbl[i].f, tbl[i].d, e, r, lat, stuck);
      n_vec++; if (lat != tbl[i].lat) begin n_bad++; $display("FAIL %s[%0d] latency: got %0d want %0d", tag, i, lat, tbl[i].lat); end
      n_vec++; if (e !== tbl[i].e) begin n_bad++; $display("FAIL %s[%0d] err: got %b want %b", tag, i, e, tbl[i].e); end
      n_vec++; if (r !== tbl[i].r) begin n_bad++; $display("FAIL %s[%0d] rdata: got %h want %h", tag, i, r, tbl[i].r); end
      n_vec++; if (stuck !== 1'b0) begin n_bad++; $display("FAIL %s[%0d] rvalid_pulse: got %b want 0", tag, i, stuck); end
    end
  endtask

  task automatic test_directed();
    vec_t t[12];
    t[0]  = '{1'b1, 32'h4, 3'b010, 32'hDEADBEEF, 1'b0, 32'h0, 2};
    t[1]  = '{1'b0, 32'h4, 3'b010, 32'h0, 1'b0, 32'hDEADBEEF, 2};
    t[2]  = '{1'b1, 32'h8, 3'b010, 32'hCAFEBABE, 1'b0, 32'h0, 2};
    t[3]  = '{1'b1, 32'h9, 3'b000, 32'h123456A5, 1'b0, 32'h0, 2};
    t[4]  = '{1'b0, 32'h8, 3'b010, 32'h0, 1'b0, 32'hCAFEA5BE, 2};
    t[5]  = '{1'b0, 32'h9, 3'b000, 32'h0, 1'b0, 32'hFFFFFFA5, 2};
    t[6]  = '{1'b0, 32'h9, 3'b100, 32'h0, 1'b0, 32'h000000A5, 2};
    t[7]  = '{1'b0, 32'h6, 3'b001, 32'h0, 1'b0, 32'hFFFFDEAD, 2};
`ifdef DMEM_MISALIGN_EN
    t[8]  = '{1'b0, 32'h6, 3'b010, 32'h0, 1'b0, 32'hA5BEDEAD, 3};
    t[9]  = '{1'b0, 32'h9, 3'b001, 32'h0, 1'b0, 32'hFFFFFEA5, 2};
`else
    t[8]  = '{1'b0, 32'h6, 3'b010, 32'h0, 1'b1, 32'h0, 1};
    t[9]  = '{1'b1, 32'h6, 3'b010, 32'h11223344, 1'b1, 32'h0, 1};
`endif
    t[10] = '{1'b0, 32'h4, 3'b010, 32'h0, 1'b0, 32'hDEADBEEF, 2};
    t[11] = '{1'b0, 32'h8, 3'b010, 32'h0, 1'b0, 32'hCAFEA5BE, 2};
    run_table("directed", t, 12);
  endtask

  task automatic test_range();
    vec_t t[9];
    t[0] = '{1'b1, 32'h40, 3'b010, 32'h55555555, 1'b1, 32'h0, 1};
    t[1] = '{1'b0, 32'h40, 3'b010, 32'h0, 1'b1, 32'h0, 1};
    t[2] = '{1'b1, 32'h4, 3'b011, 32'h77777777, 1'b1, 32'h0, 1};
    t[3] = '{1'b0, 32'h4, 3'b110, 32'h0, 1'b1, 32'h0, 1};
    t[4] = '{1'b1, 32'h8, 3'b111, 32'h66666666, 1'b1, 32'h0, 1};
    t[5] = '{1'b0, 32'h3E, 3'b010, 32'h0, 1'b1, 32'h0, 1};
    t[6] = '{1'b0, 32'h4, 3'b010, 32'h0, 1'b0, 32'hDEADBEEF, 2};
    t[7] = '{1'b0, 32'h8, 3'b010, 32'h0, 1'b0, 32'hCAFEA5BE, 2};
    t[8] = '{1'b0, 32'h3C, 3'b111, 32'h0, 1'b1, 32'h0, 1};
    run_table("range", t, 9);
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_g, exp_v;
    int nv;
    exp_g = 6'b100100;  // bit c = expected value after edge c, c = 0..5
    exp_v = 6'b100100;
    nv = 0;
    @(negedge clk);
    req = 1; we = 0; addr = 32'h4; funct3 = 3'b010; wdata = 0;
    @(posedge clk); #1;
    addr = 32'h8;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      n_vec++; if (gnt !== exp_g[c]) begin n_bad++; $display("FAIL b2b gnt@%0d: got %b want %b", c, gnt, exp_g[c]); end
      n_vec++; if (rvalid !== exp_v[c]) begin n_bad++; $display("FAIL b2b rvalid@%0d: got %b want %b", c, rvalid, exp_v[c]); end
      if (rvalid) nv++;
      if (c == 2) begin
        n_vec++; if (rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL b2b rdata0: got %h want deadbeef", rdata); end
      end
      if (c == 5) begin
        n_vec++; if (rdata !== 32'hCAFEA5BE) begin n_bad++; $display("FAIL b2b rdata1: got %h want cafea5be", rdata); end
      end
    end
    req = 0;
    for (int c = 0; c < 4; c++) begin @(posedge clk); #1; if (rvalid) nv++; end
    n_vec++; if (nv != 2) begin n_bad++; $display("FAIL b2b rvalid_count: got %0d want 2", nv); end
  endtask

  task automatic test_reset_mid();
    logic e, stuck;
    logic [31:0] r;
    int lat, nv;
    nv = 0;
    @(negedge clk);
    req = 1; we = 0; addr = 32'h8; funct3 = 3'b010;
    @(posedge clk); #1;
    req = 0; rst = 1; #2;
    n_vec++; if (gnt !== 1'b0) begin n_bad++; $display("FAIL rstmid gnt_in_rst: got %b want 0", gnt); end
    @(negedge clk); rst = 0;
    for (int c = 0; c < 5; c++) begin @(posedge clk); #1; if (rvalid) nv++; end
    n_vec++; if (nv != 0) begin n_bad++; $display("FAIL rstmid rvalid_count: got %0d want 0", nv); end
    n_vec++; if (gnt !== 1'b1) begin n_bad++; $display("FAIL rstmid gnt_after: got %b want 1", gnt); end
    do_req(1'b0, 32'h8, 3'b010, 32'h0, e, r, lat, stuck);
    n_vec++; if (r !== 32'hCAFEA5BE || e !== 1'b0 || lat != 2) begin
      n_bad++; $display("FAIL rstmid reload: got %h/%b/%0d want cafea5be/0/2", r, e, lat);
    end
`ifdef DMEM_MISALIGN_EN
    // Split store aborted in ACC1: only the lower-word half lands
    @(negedge clk);
    req = 1; we = 1; addr = 32'h6; funct3 = 3'b010; wdata = 32'h11223344;
    @(posedge clk); #1; req = 0;
    @(posedge clk); #1; rst = 1;
    @(negedge clk); rst = 0;
    do_req(1'b0, 32'h4, 3'b010, 32'h0, e, r, lat, stuck);
    n_vec++; if (r !== 32'h3344BEEF) begin n_bad++; $display("FAIL rstmid split_lo: got %h want 3344beef", r); end
    do_req(1'b0, 32'h8, 3'b010, 32'h0, e, r, lat, stuck);
    n_vec++; if (r !== 32'hCAFEA5BE) begin n_bad++; $display("FAIL rstmid split_hi: got %h want cafea5be", r); end
`endif
  endtask

  task automatic test_random();
    logic e, ee, stuck, w;
    logic [31:0] r, er, a, d;
    logic [2:0] f;
    int lat, elat;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      model(1'b1, 32'(i*4), 3'b010, d, ee, er, elat);
      do_req(1'b1, 32'(i*4), 3'b010, d, e, r, lat, stuck);
      n_vec++; if (e !== 1'b0 || lat != 2) begin n_bad++; $display("FAIL prefill[%0d]: got %b/%0d want 0/2", i, e, lat); end
    end
    for (int i = 0; i < 200; i++) begin
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      a = 32'($urandom_range(0, DEPTH*4 + 7));
      d = $urandom;
      model(w, a, f, d, ee, er, elat);
      do_req(w, a, f, d, e, r, lat, stuck);
      n_vec++; if (e !== ee || r !== er || lat != elat || stuck !== 1'b0) begin
        n_bad++;
        $display("FAIL rand[%0d] we=%b a=%h f3=%0d: got err=%b rdata=%h lat=%0d stuck=%b want err=%b rdata=%h lat=%0d",
                 i, w, a, f, e, r, lat, stuck, ee, er, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_range();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
